// File: rtl/sa_output_drain.sv
// sa_output_drain
// Drains the systolic array's output scan chain one column per cycle and
// streams each column downstream through a single-entry valid/ready register.
// Downstream back-pressure freezes the scan chain so no column is lost or
// duplicated.
// Optional feature macro: SA_DRAIN_PRELOAD_EN
//   defined   : the chain input is fed from the i_pre_* stream and capture
//               waits for i_pre_valid, preloading the next context while
//               draining.
//   undefined : zeros are shifted into the chain (accumulators end cleared),
//               o_pre_ready is tied low and i_pre_* is ignored.
module sa_output_drain #(
  parameter int X    = 3,
  parameter int Y    = 3,
  parameter int OC_W = 48,
  localparam int IDX_W = (X > 1) ? $clog2(X) : 1,
  localparam int CNT_W = $clog2(X + 1)
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_drain_start,
  output logic                o_cscan_en,
  input  logic [Y*OC_W-1:0]   i_chain_c,
  output logic [Y*OC_W-1:0]   o_chain_c,
  input  logic [Y*OC_W-1:0]   i_pre_data,
  input  logic                i_pre_valid,
  output logic                o_pre_ready,
  output logic [Y*OC_W-1:0]   o_data,
  output logic [IDX_W-1:0]    o_col_idx,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_start_err
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [Y*OC_W-1:0]   r_data;
  logic [IDX_W-1:0]    r_col_idx;
  logic                r_valid;
  logic                r_done;
  logic                r_start_err;

  logic                w_pre_ok;
  logic                w_cap;
  logic                w_hs;
  logic                w_last_hs;

`ifdef SA_DRAIN_PRELOAD_EN
  // Preload columns enter the chain in step with every capture; a missing
  // preload column stalls the whole drain so the chain never shifts in junk.
  assign w_pre_ok    = i_pre_valid;
  assign o_chain_c   = i_pre_data;
  assign o_pre_ready = w_cap;
`else
  logic w_unused;
  assign w_pre_ok    = 1'b1;
  assign o_chain_c   = '0;
  assign o_pre_ready = 1'b0;
  assign w_unused    = ^{i_pre_data, i_pre_valid};
`endif

  // A column is taken from the chain only when the output register is free
  // (or being emptied this cycle) and columns remain; the array shifts on the
  // same edge, so the shift enable is the capture strobe itself.
  assign w_cap      = (r_state == S_DRAIN) && (r_cnt < CNT_W'(X)) &&
                      (!r_valid || i_ready) && w_pre_ok;
  assign w_hs       = r_valid && i_ready;
  assign w_last_hs  = (r_state == S_DRAIN) && w_hs &&
                      (r_col_idx == IDX_W'(X - 1));
  assign o_cscan_en = w_cap;

  // Drain FSM together with the output register, capture counter and the
  // registered done / start-error pulses.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_data      <= '0;
      r_col_idx   <= '0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
      r_start_err <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_start_err <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (i_drain_start) begin
            r_state <= S_DRAIN;
            r_cnt   <= '0;
          end
        end
        S_DRAIN: begin
          if (i_drain_start) begin
            r_start_err <= 1'b1;
          end
          if (w_last_hs) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_cap) begin
        r_data    <= i_chain_c;
        r_col_idx <= r_cnt[IDX_W-1:0];
        r_valid   <= 1'b1;
        r_cnt     <= r_cnt + CNT_W'(1);
      end else if (w_hs) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data      = r_data;
  assign o_col_idx   = r_col_idx;
  assign o_valid     = r_valid;
  assign o_busy      = (r_state == S_DRAIN);
  assign o_done      = r_done;
  assign o_start_err = r_start_err;

endmodule

// File: tb/tb_sa_output_drain.sv
// tb_sa_output_drain
// Drives sa_output_drain against a behavioural model of the array's output
// scan chain and a scoreboard of the columns each drain must deliver.
// Build with +define+SA_DRAIN_PRELOAD_EN to exercise the preload variant.
`timescale 1ns/1ps
module tb_sa_output_drain;

  localparam int X     = 3;
  localparam int Y     = 3;
  localparam int OC_W  = 48;
  localparam int CW    = Y * OC_W;
  localparam int IDX_W = 2;

  typedef logic [CW-1:0] col_t;

  logic             i_clk = 1'b0;
  logic             i_rstn = 1'b0;
  logic             i_drain_start = 1'b0;
  logic             i_pre_valid = 1'b1;
  logic             i_ready = 1'b1;
  col_t             i_chain_c;
  col_t             i_pre_data;
  logic             o_cscan_en;
  col_t             o_chain_c;
  logic             o_pre_ready;
  col_t             o_data;
  logic [IDX_W-1:0] o_col_idx;
  logic             o_valid;
  logic             o_busy;
  logic             o_done;
  logic             o_start_err;

  int   total = 0;
  int   bad = 0;

  col_t chainMem [X];
  col_t loadCols [X];
  col_t preCols  [X];
  logic doLoad = 1'b0;
  int   preIdx = 0;

  col_t expQ [$];
  int   hsCount = 0;
  int   cscanCnt = 0;
  int   expIdx = 0;
  logic prevStall = 1'b0;
  col_t prevData = '0;

  sa_output_drain #(.X(X), .Y(Y), .OC_W(OC_W)) dut (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .i_drain_start(i_drain_start),
    .o_cscan_en   (o_cscan_en),
    .i_chain_c    (i_chain_c),
    .o_chain_c    (o_chain_c),
    .i_pre_data   (i_pre_data),
    .i_pre_valid  (i_pre_valid),
    .o_pre_ready  (o_pre_ready),
    .o_data       (o_data),
    .o_col_idx    (o_col_idx),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_start_err  (o_start_err)
  );

  always #5 i_clk = ~i_clk;

  // Array scan chain: each shift moves every column one place left and the
  // chain input enters at the rightmost column; the preload source advances
  // one column per consumed preload.
  always @(posedge i_clk) begin
    if (doLoad) begin
      for (int c = 0; c < X; c++) chainMem[c] <= loadCols[c];
      preIdx <= 0;
    end else begin
      if (o_cscan_en) begin
        for (int c = 0; c < X - 1; c++) chainMem[c] <= chainMem[c + 1];
        chainMem[X - 1] <= o_chain_c;
      end
      if (o_pre_ready) preIdx <= preIdx + 1;
    end
  end

  assign i_chain_c  = chainMem[0];
  assign i_pre_data = (preIdx < X) ? preCols[preIdx] : '0;

  task automatic checkOutput(input string tag, input col_t got, input col_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic col_t mkCol(input logic [OC_W-1:0] v);
    col_t r;
    for (int i = 0; i < Y; i++) r[i*OC_W +: OC_W] = v;
    return r;
  endfunction

  function automatic col_t randCol();
    col_t v;
    for (int b = 0; b < CW; b += 16) v[b +: 16] = 16'($urandom());
    return v;
  endfunction

  task automatic setCols(input int a, input int b, input int c);
    loadCols[0] = mkCol(OC_W'(a));
    loadCols[1] = mkCol(OC_W'(b));
    loadCols[2] = mkCol(OC_W'(c));
  endtask

  task automatic stepCycle();
    @(posedge i_clk);
    #1;
  endtask

  // Loads the chain and pulses start on the same edge; the columns this drain
  // must deliver are queued once that edge has passed.
  task automatic kickDrain();
    doLoad = 1'b1;
    i_drain_start = 1'b1;
    stepCycle();
    doLoad = 1'b0;
    i_drain_start = 1'b0;
    for (int c = 0; c < X; c++) expQ.push_back(loadCols[c]);
  endtask

  task automatic waitDone(input string tag);
    int cyc = 0;
    while (!o_done && cyc < 100) begin
      stepCycle();
      cyc++;
    end
    checkOutput(tag, col_t'(o_done), col_t'(1));
  endtask

  // After a complete drain the chain holds the preload columns in injection
  // order, or nothing but zeros when preload is not built in.
  task automatic checkChain();
    for (int c = 0; c < X; c++) begin
`ifdef SA_DRAIN_PRELOAD_EN
      checkOutput("chainPre", chainMem[c], preCols[c]);
`else
      checkOutput("chainClr", chainMem[c], '0);
`endif
    end
  endtask

  task automatic applyStimulus(input int readyPct, input int prePct);
    int cyc = 0;
    for (int c = 0; c < X; c++) begin
      loadCols[c] = randCol();
      preCols[c]  = randCol();
    end
    kickDrain();
    while (!o_done && cyc < 200) begin
      i_ready     = ($urandom_range(99) < readyPct);
      i_pre_valid = ($urandom_range(99) < prePct);
      stepCycle();
      cyc++;
    end
    checkOutput("randDone", col_t'(o_done), col_t'(1));
    i_ready     = 1'b1;
    i_pre_valid = 1'b1;
    checkChain();
  endtask

  // Scoreboard and protocol monitor, sampled on the inactive clock edge.
  always @(negedge i_clk) begin
    if (!i_rstn) begin
      expQ.delete();
      hsCount   = 0;
      cscanCnt  = 0;
      expIdx    = 0;
      prevStall = 1'b0;
    end else begin
      if (prevStall && o_valid) checkOutput("holdData", o_data, prevData);
      checkOutput("scanBusy", col_t'(o_cscan_en & ~o_busy), '0);
      checkOutput("bpScan", col_t'(o_valid & ~i_ready & o_cscan_en), '0);
`ifdef SA_DRAIN_PRELOAD_EN
      checkOutput("preStall", col_t'(o_cscan_en & ~i_pre_valid), '0);
      checkOutput("preReady", col_t'(o_pre_ready), col_t'(o_cscan_en));
`else
      checkOutput("preReadyTie", col_t'(o_pre_ready), '0);
`endif
      if (o_cscan_en) cscanCnt++;
      if (o_valid && i_ready) begin
        checkOutput("colExpected", col_t'(expQ.size() > 0), col_t'(1));
        if (expQ.size() > 0) begin
          checkOutput("colData", o_data, expQ.pop_front());
          checkOutput("colIdx", col_t'(o_col_idx), col_t'(expIdx));
        end
        hsCount++;
        expIdx++;
      end
      if (o_done) begin
        checkOutput("doneCols", col_t'(hsCount), col_t'(X));
        checkOutput("doneScans", col_t'(cscanCnt), col_t'(X));
        checkOutput("doneQueue", col_t'(expQ.size()), '0);
        hsCount  = 0;
        cscanCnt = 0;
        expIdx   = 0;
      end
      prevStall = o_valid && !i_ready;
      prevData  = o_data;
    end
  end

  // Watchdog so a stuck DUT still ends the run with a visible failure.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion expected test end");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by randomized drains.
  initial begin
    for (int c = 0; c < X; c++) preCols[c] = mkCol(OC_W'(c + 1));
    setCols(0, 0, 0);

    repeat (2) @(posedge i_clk);
    #1;
    checkOutput("rstValid", col_t'(o_valid), '0);
    checkOutput("rstData", o_data, '0);
    checkOutput("rstIdx", col_t'(o_col_idx), '0);
    checkOutput("rstDone", col_t'(o_done), '0);
    checkOutput("rstErr", col_t'(o_start_err), '0);
    checkOutput("rstBusy", col_t'(o_busy), '0);
    checkOutput("rstScan", col_t'(o_cscan_en), '0);
    checkOutput("rstPreRdy", col_t'(o_pre_ready), '0);
`ifdef SA_DRAIN_PRELOAD_EN
    checkOutput("rstChainIn", o_chain_c, i_pre_data);
`else
    checkOutput("rstChainIn", o_chain_c, '0);
`endif
    i_rstn = 1'b1;
    stepCycle();

    $display("[TB] full-rate drain");
    setCols(10, 20, 30);
    i_ready = 1'b1;
    kickDrain();
    checkOutput("latBusy", col_t'(o_busy), col_t'(1));
    checkOutput("latScan", col_t'(o_cscan_en), col_t'(1));
    checkOutput("latValid", col_t'(o_valid), '0);
    for (int c = 0; c < X; c++) begin
      stepCycle();
      checkOutput("frValid", col_t'(o_valid), col_t'(1));
      checkOutput("frIdx", col_t'(o_col_idx), col_t'(c));
      checkOutput("frData", o_data, mkCol(OC_W'((c + 1) * 10)));
      checkOutput("frScan", col_t'(o_cscan_en), col_t'(c < X - 1));
    end
    stepCycle();
    checkOutput("frDone", col_t'(o_done), col_t'(1));
    checkOutput("frIdle", col_t'(o_busy), '0);
    checkOutput("frValidLow", col_t'(o_valid), '0);
    checkChain();
    stepCycle();
    checkOutput("frDoneOnce", col_t'(o_done), '0);

    $display("[TB] back-pressure");
    setCols(10, 20, 30);
    i_ready = 1'b0;
    kickDrain();
    stepCycle();
    for (int k = 0; k < 4; k++) begin
      checkOutput("bpValid", col_t'(o_valid), col_t'(1));
      checkOutput("bpData", o_data, mkCol(OC_W'(10)));
      checkOutput("bpHoldScan", col_t'(o_cscan_en), '0);
      if (k < 3) stepCycle();
    end
    i_ready = 1'b1;
    waitDone("bpDone");
    stepCycle();

    $display("[TB] start while busy");
    setCols(11, 21, 31);
    kickDrain();
    stepCycle();
    stepCycle();
    checkOutput("sbIdx", col_t'(o_col_idx), col_t'(1));
    i_drain_start = 1'b1;
    stepCycle();
    i_drain_start = 1'b0;
    checkOutput("sbErr", col_t'(o_start_err), col_t'(1));
    stepCycle();
    checkOutput("sbErrClr", col_t'(o_start_err), '0);
    checkOutput("sbDone", col_t'(o_done), col_t'(1));

    $display("[TB] back-to-back drains");
    setCols(12, 22, 32);
    kickDrain();
    checkOutput("b2bBusy", col_t'(o_busy), col_t'(1));
    checkOutput("b2bNoErr", col_t'(o_start_err), '0);
    checkOutput("b2bValid0", col_t'(o_valid), '0);
    stepCycle();
    checkOutput("b2bValid1", col_t'(o_valid), col_t'(1));
    waitDone("b2bDone");
    stepCycle();

    $display("[TB] reset mid-drain");
    setCols(13, 23, 33);
    kickDrain();
    stepCycle();
    stepCycle();
    #2;
    i_rstn = 1'b0;
    #1;
    checkOutput("arValid", col_t'(o_valid), '0);
    checkOutput("arBusy", col_t'(o_busy), '0);
    checkOutput("arData", o_data, '0);
    checkOutput("arIdx", col_t'(o_col_idx), '0);
    checkOutput("arScan", col_t'(o_cscan_en), '0);
    for (int k = 0; k < 2; k++) begin
      stepCycle();
      checkOutput("arScanHeld", col_t'(o_cscan_en), '0);
    end
    i_rstn = 1'b1;
    stepCycle();
    checkOutput("arIdleAfter", col_t'(o_busy), '0);

`ifdef SA_DRAIN_PRELOAD_EN
    $display("[TB] preload with gap");
    setCols(14, 24, 34);
    for (int c = 0; c < X; c++) preCols[c] = mkCol(OC_W'(c + 1));
    kickDrain();
    stepCycle();
    i_pre_valid = 1'b0;
    #1;
    checkOutput("gapScan0", col_t'(o_cscan_en), '0);
    stepCycle();
    checkOutput("gapScan1", col_t'(o_cscan_en), '0);
    checkOutput("gapValid", col_t'(o_valid), '0);
    i_pre_valid = 1'b1;
    waitDone("preDone");
    checkChain();
    stepCycle();
`endif

    $display("[TB] randomized drains");
    for (int n = 0; n < 12; n++) begin
      applyStimulus(int'($urandom_range(100, 40)), int'($urandom_range(100, 40)));
    end
    stepCycle();
    stepCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
